// File: rtl/fu_alloc_pkg.sv
// Shared defaults and elaboration helpers for the round-robin FU allocator.
package fu_alloc_pkg;

  localparam int DEF_NUM_SLOTS = 2;
  localparam int DEF_NUM_FU    = 4;
  localparam int DEF_LAT_W     = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fu_busy_ctr.sv
// One FU occupancy counter: loads a latency on grant, counts down to free.
module fu_busy_ctr #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [LAT_W-1:0] lat,
  output logic             busy
);

  logic [LAT_W-1:0] cnt;

  // A zero latency still occupies the unit for one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush)     cnt <= '0;
    else if (load)        cnt <= (lat == '0) ? LAT_W'(1) : lat;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign busy = |cnt;

endmodule

// File: rtl/fu_rr_alloc.sv
// In-order multi-slot FU allocator with round-robin free-unit search.
// Optional stall statistics counter enabled by defining FU_RR_STATS_EN.
module fu_rr_alloc
  import fu_alloc_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int NUM_FU    = DEF_NUM_FU,
  parameter int LAT_W     = DEF_LAT_W,
  parameter int FU_IDW    = clog2(NUM_FU)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SLOTS-1:0]        slot_valid,
  input  logic [NUM_SLOTS*LAT_W-1:0]  slot_lat,
  input  logic                        flush,
  output logic [NUM_SLOTS-1:0]        slot_grant,
  output logic [NUM_SLOTS*FU_IDW-1:0] slot_fu_id,
  output logic [NUM_FU-1:0]           fu_busy,
  output logic                        stall,
  output logic [15:0]                 stall_cnt
);

  logic [FU_IDW-1:0]            rr_ptr, rr_nxt, last_fu, idx, sel;
  logic [NUM_FU-1:0]            busy, taken, load;
  logic [NUM_FU-1:0][LAT_W-1:0] fu_lat;
  logic                         blocked, found, any_grant, kill;

  assign kill = rst | flush;

  // Slots are served in order; the first valid slot that finds no free unit
  // blocks every slot above it. Units already taken this cycle are masked.
  always_comb begin
    slot_grant = '0;
    slot_fu_id = '0;
    load       = '0;
    fu_lat     = '0;
    taken      = '0;
    blocked    = 1'b0;
    found      = 1'b0;
    any_grant  = 1'b0;
    last_fu    = '0;
    idx        = '0;
    sel        = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_valid[k] && !kill && !blocked) begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
          idx = FU_IDW'((int'(rr_ptr) + i) % NUM_FU);
          if (!found && !busy[idx] && !taken[idx]) begin
            found = 1'b1;
            sel   = idx;
          end
        end
        if (found) begin
          slot_grant[k]                    = 1'b1;
          slot_fu_id[k*FU_IDW +: FU_IDW]   = sel;
          taken[sel]                       = 1'b1;
          load[sel]                        = 1'b1;
          fu_lat[sel]                      = slot_lat[k*LAT_W +: LAT_W];
          any_grant                        = 1'b1;
          last_fu                          = sel;
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  assign rr_nxt  = FU_IDW'((int'(last_fu) + 1) % NUM_FU);
  assign stall   = !kill && |(slot_valid & ~slot_grant);
  assign fu_busy = busy;

  always_ff @(posedge clk) begin
    if (rst)            rr_ptr <= '0;
    else if (any_grant) rr_ptr <= rr_nxt;
  end

  for (genvar j = 0; j < NUM_FU; j++) begin : g_fu
    fu_busy_ctr #(.LAT_W(LAT_W)) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .load  (load[j]),
      .lat   (fu_lat[j]),
      .busy  (busy[j])
    );
  end

`ifdef FU_RR_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst)                             stall_q <= '0;
    else if (stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fu_rr_alloc.sv
// Directed bench for fu_rr_alloc at default parameters (2 slots, 4 FUs).
module tb_fu_rr_alloc;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  slot_valid;
  logic [5:0]  slot_lat;
  logic [1:0]  slot_grant;
  logic [3:0]  slot_fu_id;
  logic [3:0]  fu_busy;
  logic        stall;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

`ifdef FU_RR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  fu_rr_alloc dut (
    .clk        (clk),
    .rst        (rst),
    .slot_valid (slot_valid),
    .slot_lat   (slot_lat),
    .flush      (flush),
    .slot_grant (slot_grant),
    .slot_fu_id (slot_fu_id),
    .fu_busy    (fu_busy),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] v, input logic [2:0] l1, input logic [2:0] l0);
    slot_valid = v;
    slot_lat   = {l1, l0};
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0;
    drv(2'b11, 3'd1, 3'd1);
    checks++; if (slot_grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", slot_grant); end
    checks++; if (slot_fu_id !== 4'h0) begin errors++; $display("FAIL rst_id got %h exp 0", slot_fu_id); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall); end
    tick; tick;
    checks++; if (fu_busy !== 4'b0000) begin errors++; $display("FAIL rst_busy got %b exp 0000", fu_busy); end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL rst_ptr got %0d exp 0", dut.rr_ptr); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_scnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_basic;
    rst = 1'b0;
    drv(2'b11, 3'd1, 3'd1);
    checks++; if (slot_grant !== 2'b11) begin errors++; $display("FAIL basic_grant got %b exp 11", slot_grant); end
    checks++; if (slot_fu_id !== 4'b0100) begin errors++; $display("FAIL basic_id got %b exp 0100", slot_fu_id); end
    tick;
    checks++; if (dut.rr_ptr !== 2'd2) begin errors++; $display("FAIL basic_ptr got %0d exp 2", dut.rr_ptr); end
    checks++; if (fu_busy !== 4'b0011) begin errors++; $display("FAIL basic_busy got %b exp 0011", fu_busy); end
  endtask

  task automatic test_occupancy;
    drv(2'b11, 3'd3, 3'd3);
    checks++; if (slot_grant !== 2'b11) begin errors++; $display("FAIL occ_grant got %b exp 11", slot_grant); end
    checks++; if (slot_fu_id !== 4'b1110) begin errors++; $display("FAIL occ_id got %b exp 1110", slot_fu_id); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL occ_stall got %b exp 0", stall); end
    tick;
    drv(2'b00, 3'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (fu_busy !== 4'b1100) begin errors++; $display("FAIL occ_busy%0d got %b exp 1100", i, fu_busy); end
      tick;
    end
    checks++; if (fu_busy !== 4'b0000) begin errors++; $display("FAIL occ_free got %b exp 0000", fu_busy); end
  endtask

  task automatic test_partial;
    drv(2'b11, 3'd4, 3'd4);
    tick;
    drv(2'b01, 3'd0, 3'd4);
    checks++; if (slot_fu_id !== 4'b0010) begin errors++; $display("FAIL part_fill got %b exp 0010", slot_fu_id); end
    tick;
    drv(2'b11, 3'd2, 3'd2);
    checks++; if (slot_grant !== 2'b01) begin errors++; $display("FAIL part_grant got %b exp 01", slot_grant); end
    checks++; if (slot_fu_id !== 4'b0011) begin errors++; $display("FAIL part_id got %b exp 0011", slot_fu_id); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL part_stall got %b exp 1", stall); end
    tick;
    exp_stall++;
    drv(2'b00, 3'd0, 3'd0);
    checks++; if (stall_cnt !== (STATS ? 16'(exp_stall) : 16'd0)) begin errors++; $display("FAIL part_scnt got %0d exp %0d", stall_cnt, STATS ? exp_stall : 0); end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL part_ptr got %0d exp 0", dut.rr_ptr); end
    repeat (4) tick;
    checks++; if (fu_busy !== 4'b0000) begin errors++; $display("FAIL part_drain got %b exp 0000", fu_busy); end
  endtask

  task automatic test_skip;
    drv(2'b01, 3'd0, 3'd1);
    checks++; if (slot_grant !== 2'b01) begin errors++; $display("FAIL skip_pre got %b exp 01", slot_grant); end
    tick;
    drv(2'b10, 3'd0, 3'd1);
    checks++; if (slot_grant !== 2'b10) begin errors++; $display("FAIL skip_grant got %b exp 10", slot_grant); end
    checks++; if (slot_fu_id !== 4'b0100) begin errors++; $display("FAIL skip_id got %b exp 0100", slot_fu_id); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL skip_stall got %b exp 0", stall); end
    tick;
    drv(2'b00, 3'd0, 3'd0);
    checks++; if (fu_busy !== 4'b0010) begin errors++; $display("FAIL lat0_busy got %b exp 0010", fu_busy); end
    checks++; if (dut.rr_ptr !== 2'd2) begin errors++; $display("FAIL skip_ptr got %0d exp 2", dut.rr_ptr); end
    tick;
    checks++; if (fu_busy !== 4'b0000) begin errors++; $display("FAIL lat0_free got %b exp 0000", fu_busy); end
  endtask

  task automatic test_expiring;
    drv(2'b11, 3'd4, 3'd2);
    checks++; if (slot_fu_id !== 4'b1110) begin errors++; $display("FAIL exp_id0 got %b exp 1110", slot_fu_id); end
    tick;
    drv(2'b11, 3'd4, 3'd4);
    checks++; if (slot_fu_id !== 4'b0100) begin errors++; $display("FAIL exp_id1 got %b exp 0100", slot_fu_id); end
    tick;
    drv(2'b01, 3'd0, 3'd1);
    checks++; if (fu_busy !== 4'b1111) begin errors++; $display("FAIL exp_full got %b exp 1111", fu_busy); end
    checks++; if (slot_grant !== 2'b00) begin errors++; $display("FAIL exp_nogrant got %b exp 00", slot_grant); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL exp_stall got %b exp 1", stall); end
    tick;
    exp_stall++;
    drv(2'b01, 3'd0, 3'd1);
    checks++; if (stall_cnt !== (STATS ? 16'(exp_stall) : 16'd0)) begin errors++; $display("FAIL exp_scnt got %0d exp %0d", stall_cnt, STATS ? exp_stall : 0); end
    checks++; if (slot_grant !== 2'b01) begin errors++; $display("FAIL exp_regrant got %b exp 01", slot_grant); end
    checks++; if (slot_fu_id !== 4'b0010) begin errors++; $display("FAIL exp_reid got %b exp 0010", slot_fu_id); end
    tick;
    drv(2'b00, 3'd0, 3'd0);
    repeat (3) tick;
    checks++; if (fu_busy !== 4'b0000) begin errors++; $display("FAIL exp_drain got %b exp 0000", fu_busy); end
    checks++; if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL exp_ptr got %0d exp 3", dut.rr_ptr); end
  endtask

  task automatic test_flush;
    drv(2'b11, 3'd7, 3'd7);
    checks++; if (slot_fu_id !== 4'b0011) begin errors++; $display("FAIL fl_id0 got %b exp 0011", slot_fu_id); end
    tick;
    drv(2'b11, 3'd7, 3'd7);
    checks++; if (slot_fu_id !== 4'b1001) begin errors++; $display("FAIL fl_id1 got %b exp 1001", slot_fu_id); end
    tick;
    flush = 1'b1;
    drv(2'b11, 3'd7, 3'd7);
    checks++; if (fu_busy !== 4'b1111) begin errors++; $display("FAIL fl_full got %b exp 1111", fu_busy); end
    checks++; if (slot_grant !== 2'b00) begin errors++; $display("FAIL fl_grant got %b exp 00", slot_grant); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %b exp 0", stall); end
    tick;
    flush = 1'b0;
    drv(2'b00, 3'd0, 3'd0);
    checks++; if (fu_busy !== 4'b0000) begin errors++; $display("FAIL fl_busy got %b exp 0000", fu_busy); end
    checks++; if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL fl_ptr got %0d exp 3", dut.rr_ptr); end
    checks++; if (stall_cnt !== (STATS ? 16'(exp_stall) : 16'd0)) begin errors++; $display("FAIL fl_scnt got %0d exp %0d", stall_cnt, STATS ? exp_stall : 0); end
    drv(2'b01, 3'd0, 3'd1);
    checks++; if (slot_fu_id !== 4'b0011) begin errors++; $display("FAIL fl_after got %b exp 0011", slot_fu_id); end
    tick;
    drv(2'b00, 3'd0, 3'd0);
    tick;
  endtask

  task automatic test_reset_mid;
    drv(2'b11, 3'd5, 3'd1);
    checks++; if (slot_fu_id !== 4'b0100) begin errors++; $display("FAIL rm_id got %b exp 0100", slot_fu_id); end
    tick;
    rst = 1'b1; flush = 1'b1;
    drv(2'b11, 3'd2, 3'd2);
    checks++; if (slot_grant !== 2'b00) begin errors++; $display("FAIL rm_grant got %b exp 00", slot_grant); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rm_stall got %b exp 0", stall); end
    checks++; if (fu_busy !== 4'b0011) begin errors++; $display("FAIL rm_busy got %b exp 0011", fu_busy); end
    tick;
    rst = 1'b0; flush = 1'b0;
    exp_stall = 0;
    drv(2'b00, 3'd0, 3'd0);
    checks++; if (fu_busy !== 4'b0000) begin errors++; $display("FAIL rm_free got %b exp 0000", fu_busy); end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL rm_ptr got %0d exp 0", dut.rr_ptr); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rm_scnt got %0d exp 0", stall_cnt); end
    drv(2'b11, 3'd1, 3'd1);
    checks++; if (slot_fu_id !== 4'b0100) begin errors++; $display("FAIL rm_after got %b exp 0100", slot_fu_id); end
    tick;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; slot_valid = '0; slot_lat = '0;
    test_reset;
    test_basic;
    test_occupancy;
    test_partial;
    test_skip;
    test_expiring;
    test_flush;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
